// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default widths.
package div_pkg;

  localparam int DIV_N = 8;
  localparam int DIV_M = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and report the quotient bit.
module div_step #(
  parameter int M = 8
) (
  input  logic [M:0]   rem_i,
  input  logic         a_msb_i,
  input  logic [M-1:0] b_i,
  output logic [M:0]   rem_o,
  output logic         q_bit_o
);

  logic [M+1:0] shifted;
  logic [M:0]   diff;

  always_comb begin
    shifted = {rem_i, a_msb_i};
    // A zero divisor always "fits", which yields an all-ones quotient and
    // leaves the dividend's low bits in the remainder.
    q_bit_o = (shifted >= {2'b00, b_i});
    diff    = shifted[M:0] - {1'b0, b_i};
    rem_o   = q_bit_o ? diff : shifted[M:0];
  end

endmodule

// File: rtl/seq_div_usign.sv
// Sequential restoring divider, one quotient bit per clock, latency N+1 cycles.
// Defining SEQ_DIV_SIGNED_EN adds port sg for two's-complement operation.
module seq_div_usign
  import div_pkg::*;
#(
  parameter int N = DIV_N,
  parameter int M = DIV_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [M-1:0] B,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic         sg,
`endif
  output logic [N-1:0] Q,
  output logic [M-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         dz
);

  localparam int CW = $clog2(N + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d;
  logic [M-1:0]   b_q, b_d;
  logic [M:0]     rem_q, rem_d;
  logic           q_neg_q, q_neg_d;
  logic           r_neg_q, r_neg_d;
  logic [N-1:0]   q_q, q_d;
  logic [M-1:0]   r_q, r_d;
  logic           dz_q, dz_d;

  logic [N-1:0]   a_in;
  logic [M-1:0]   b_in;
  logic           q_neg_in, r_neg_in;
  logic [M:0]     step_rem;
  logic           step_q_bit;

  div_step #(.M(M)) u_step (
    .rem_i   (rem_q),
    .a_msb_i (a_q[N-1]),
    .b_i     (b_q),
    .rem_o   (step_rem),
    .q_bit_o (step_q_bit)
  );

  // Operands are reduced to magnitudes at capture; signs are reapplied at completion.
  always_comb begin
    a_in     = A;
    b_in     = B;
    q_neg_in = 1'b0;
    r_neg_in = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
    if (sg && (B != '0)) begin
      a_in     = A[N-1] ? -A : A;
      b_in     = B[M-1] ? -B : B;
      q_neg_in = A[N-1] ^ B[M-1];
      r_neg_in = A[N-1];
    end
`endif
  end

  // NOTE: every next-state signal gets its default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          rem_d   = '0;
          cnt_d   = '0;
          q_neg_d = q_neg_in;
          r_neg_d = r_neg_in;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == CW'(N)) begin
          q_d     = q_neg_q ? -a_q : a_q;
          r_d     = r_neg_q ? -rem_q[M-1:0] : rem_q[M-1:0];
          dz_d    = (b_q == '0);
          state_d = DONE;
        end else begin
          // The dividend register doubles as the quotient: bits shift out the top, results in at the bottom.
          a_d   = (a_q << 1) | N'(step_q_bit);
          rem_d = step_rem;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign dz   = dz_q;
  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_div_usign.sv
// Self-checking bench for seq_div_usign (N=M=8): expected results are queued
// at start and compared when done pulses.
module tb_seq_div_usign;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic [7:0] q, r;
  logic       busy, done, dz;
`ifdef SEQ_DIV_SIGNED_EN
  logic       sg;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_div_usign #(.N(8), .M(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
`ifdef SEQ_DIV_SIGNED_EN
    .sg    (sg),
`endif
    .Q     (q),
    .R     (r),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  function automatic exp_t model_u(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    if (y == 8'd0) e = '{q: 8'hFF, r: x, dz: 1'b1};
    else           e = '{q: x / y, r: x % y, dz: 1'b0};
    return e;
  endfunction

  function automatic exp_t model_s(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   sx, sy, qi, ri;
    if (y == 8'd0) return model_u(x, y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    qi = sx / sy;
    ri = sx % sy;
    e  = '{q: qi[7:0], r: ri[7:0], dz: 1'b0};
    return e;
  endfunction

  task automatic drive_start(input logic [7:0] x, input logic [7:0] y, input exp_t e);
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back(e);
  endtask

  // Called at the negedge where start is driven; returns at the negedge where done is seen.
  task automatic wait_done(input int inject_at, input logic [7:0] inject_a,
                           output int cycles, output int busy_cycles, output bit timed_out);
    cycles      = 0;
    busy_cycles = 0;
    timed_out   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_cycles++;
      if (cycles == inject_at) begin
        start = 1'b1;
        a     = inject_a;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
`ifdef SEQ_DIV_SIGNED_EN
    sg    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if ({q, r, dz} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: Q=%0d R=%0d dz=%0d, expected all 0", q, r, dz);
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_status: busy=%0b done=%0b, expected 0 0", busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc, bcyc; bit to; exp_t e, got;
    drive_start(8'd200, 8'd7, model_u(8'd200, 8'd7));
    wait_done(-1, 8'd0, cyc, bcyc, to);
    checks++;
    if (to || cyc != 10) begin
      errors++;
      $display("FAIL basic_latency: timeout=%0b cycles=%0d, expected done 9 cycles after E0", to, cyc - 1);
    end
    checks++;
    if (bcyc != 9) begin
      errors++;
      $display("FAIL basic_busy: busy high %0d cycles, expected 9", bcyc);
    end
    e = sb.pop_front();
    got = '{q: q, r: r, dz: dz};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL basic_result: Q=%0d R=%0d dz=%0d, expected Q=%0d R=%0d dz=%0d", q, r, dz, e.q, e.r, e.dz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || q !== e.q || r !== e.r) begin
      errors++;
      $display("FAIL basic_hold: done=%0b Q=%0d R=%0d, expected done=0 Q=%0d R=%0d", done, q, r, e.q, e.r);
    end
  endtask

  task automatic test_div_zero();
    int cyc, bcyc; bit to; exp_t e, got;
    drive_start(8'd13, 8'd0, model_u(8'd13, 8'd0));
    wait_done(-1, 8'd0, cyc, bcyc, to);
    checks++;
    if (to || cyc != 10) begin
      errors++;
      $display("FAIL divzero_latency: timeout=%0b cycles=%0d, expected 9", to, cyc - 1);
    end
    e = sb.pop_front();
    got = '{q: q, r: r, dz: dz};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL divzero_result: Q=%0d R=%0d dz=%0d, expected Q=%0d R=%0d dz=%0d", q, r, dz, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bcyc; bit to; exp_t e, got;
    drive_start(8'd100, 8'd3, model_u(8'd100, 8'd3));
    wait_done(4, 8'd50, cyc, bcyc, to);
    checks++;
    if (to || cyc != 10) begin
      errors++;
      $display("FAIL ignore_latency: timeout=%0b cycles=%0d, expected 9", to, cyc - 1);
    end
    e = sb.pop_front();
    got = '{q: q, r: r, dz: dz};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL ignore_result: Q=%0d R=%0d dz=%0d, expected Q=%0d R=%0d dz=%0d", q, r, dz, e.q, e.r, e.dz);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: busy=%0b done=%0b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc; bit to; int seen_done; exp_t e, got;
    drive_start(8'd100, 8'd3, model_u(8'd100, 8'd3));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({q, r, dz, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: Q=%0d R=%0d dz=%0d busy=%0b done=%0b, expected all 0", q, r, dz, busy, done);
    end
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d cycles with busy/done after reset, expected 0", seen_done);
    end
    // First start right after reset release must be accepted.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_start(8'd9, 8'd4, model_u(8'd9, 8'd4));
    wait_done(-1, 8'd0, cyc, bcyc, to);
    e = sb.pop_front();
    got = '{q: q, r: r, dz: dz};
    checks++;
    if (to || cyc != 10 || got !== e) begin
      errors++;
      $display("FAIL reset_recover: timeout=%0b cycles=%0d Q=%0d R=%0d dz=%0d, expected 9 cycles Q=%0d R=%0d dz=%0d",
               to, cyc - 1, q, r, dz, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc; bit to; exp_t e, got;
    logic [7:0] x, y;
    x = 8'($urandom_range(0, 255));
    y = 8'($urandom_range(0, 255));
    drive_start(x, y, model_u(x, y));
    for (int i = 0; i < 50; i++) begin
      wait_done(-1, 8'd0, cyc, bcyc, to);
      checks++;
      if (to || cyc != 10) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: timeout=%0b cycles=%0d, expected 9", i, to, cyc - 1);
      end
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL b2b_scoreboard[%0d]: queue empty, expected one entry", i);
        break;
      end
      e = sb.pop_front();
      got = '{q: q, r: r, dz: dz};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL b2b_result[%0d]: Q=%0d R=%0d dz=%0d, expected Q=%0d R=%0d dz=%0d", i, q, r, dz, e.q, e.r, e.dz);
      end
      if (i < 49) begin
        x = 8'($urandom_range(0, 255));
        y = (i % 8 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
        drive_start(x, y, model_u(x, y));
      end
    end
    start = 1'b0;
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed();
    int cyc, bcyc; bit to; exp_t e, got;
    logic [7:0] xs [3] = '{8'h9C, 8'h64, 8'hF3};
    logic [7:0] ys [3] = '{8'h07, 8'hF9, 8'h00};
    sg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_start(xs[i], ys[i], model_s(xs[i], ys[i]));
      wait_done(-1, 8'd0, cyc, bcyc, to);
      e = sb.pop_front();
      got = '{q: q, r: r, dz: dz};
      checks++;
      if (to || cyc != 10 || got !== e) begin
        errors++;
        $display("FAIL signed_result[%0d]: timeout=%0b cycles=%0d Q=%h R=%h dz=%0d, expected 9 cycles Q=%h R=%h dz=%0d",
                 i, to, cyc - 1, q, r, dz, e.q, e.r, e.dz);
      end
    end
    sg = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_div_usign.md
SEQ_DIV_USIGN -- requirements
Module: seq_div_usign

Interface
REQ-001 Parameter N, default 8: dividend and quotient width in bits.
REQ-002 Parameter M, default 8: divisor and remainder width in bits.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to begin a division with the current A and B.
REQ-006 A  input  N  dividend.
REQ-007 B  input  M  divisor.
REQ-008 Q  output  N  quotient, registered.
REQ-009 R  output  M  remainder, registered.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 done  output  1  single-cycle pulse marking Q, R and dz valid.
REQ-012 dz  output  1  divide-by-zero flag, valid with done.

Function
REQ-013 The block SHALL implement restoring division, one quotient bit per clock, MSB first, with an (M+1)-bit partial remainder.
REQ-014 The states SHALL be IDLE, BUSY and DONE: IDLE->BUSY on start; BUSY->DONE after N iterations; DONE->BUSY on start, else DONE->IDLE.
REQ-015 start sampled high in IDLE or DONE SHALL capture A and B on the same edge (E0); later changes to A and B SHALL NOT affect the result.
REQ-016 Iterations SHALL occur on edges E1..EN; done SHALL be high for exactly the one cycle after edge EN+1, giving latency N+1 cycles.
REQ-017 busy SHALL be high from E0 until edge EN+1, and low otherwise.
REQ-018 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-019 Q and R SHALL update only at edge EN+1 and hold their values until the next completion or reset.
REQ-020 When B=0, the block SHALL return Q all ones, R=A[M-1:0] zero-extended or truncated, and dz=1, with unchanged latency.
REQ-021 When B is not 0, dz SHALL be 0 and A = Q*B + R with R < B.
REQ-022 start sampled in the DONE cycle SHALL begin a new operation back-to-back, with no idle cycle.

Reset
REQ-023 rst=1 SHALL force IDLE immediately and clear Q, R, busy, done, dz and all internal registers to 0, including mid-operation.
REQ-024 After rst falls, the first start SHALL be sampled on the first rising edge with rst=0.

Configuration
REQ-025 With SEQ_DIV_SIGNED_EN defined, the block SHALL add input port sg (1 bit), sampled at E0; sg=1 treats A, B, Q and R as two's complement.
REQ-026 Signed mode SHALL divide magnitudes, round the quotient toward zero, and give R the sign of A.
REQ-027 Signed mode SHALL keep the latency at N+1 cycles, and the B=0 rule of REQ-020 SHALL still apply.
REQ-028 Without SEQ_DIV_SIGNED_EN, port sg SHALL be absent and operation SHALL be unsigned only.

Structure
REQ-029 Package div_pkg SHALL hold the state typedef (IDLE/BUSY/DONE) and the default width constants DIV_N=8 and DIV_M=8.
REQ-030 One combinational sub-module, div_step, SHALL perform a single shift-subtract-restore step; seq_div_usign SHALL instantiate it once and iterate it.

Verification (N=8, M=8)
REQ-031 A=200, B=7, start pulsed at E0 -> done at E0+9 with Q=28, R=4, dz=0; busy high for 9 cycles.
REQ-032 A=13, B=0 -> Q=255, R=13, dz=1 after 9 cycles.
REQ-033 A=100, B=3, then start re-pulsed with A=50 at E0+4 -> ignored; result Q=33, R=1.
REQ-034 rst pulsed at E0+5 of a division -> all outputs 0, state IDLE; no done pulse follows.
REQ-035 50 random A/B pairs, start asserted in each DONE cycle -> every result satisfies Q=A/B and R=A%B (B=0 per REQ-032), and each operation completes in 9 cycles.
REQ-036 SEQ_DIV_SIGNED_EN defined, sg=1, A=-100 (0x9C), B=7 -> Q=0xF2 (-14), R=0xFE (-2).
